// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS integer register file.
// The register file top and its read-port sub-module both import this package.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // A write takes effect (and may be forwarded) only outside reset and never to $0.
    function automatic logic write_active(input logic we, input logic rst, input reg_idx_t widx);
        return we && !rst && (widx != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: NUM_REGS:1 word select, $0 forced to zero,
// and optional forwarding of the write in flight when the indices match.
import mips_pkg::*;

module regfile_read_port #(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int ADDR_W   = mips_pkg::ADDR_W,
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter bit BYPASS   = 1'b1
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs_i,
    input  logic [ADDR_W-1:0]               raddr_i,
    input  logic                            wr_act_i,
    input  logic [ADDR_W-1:0]               waddr_i,
    input  logic [DATA_W-1:0]               wdata_i,
    output logic [DATA_W-1:0]               rdata_o
);

    logic              fwd_hit;
    logic [DATA_W-1:0] stored;

    // wr_act_i already excludes reset and $0, so a match here is a legal forward.
    assign fwd_hit = BYPASS && wr_act_i && (waddr_i == raddr_i);
    assign stored  = regs_i[raddr_i];

    always_comb begin
        rdata_o = stored;
        if (fwd_hit) begin
            rdata_o = wdata_i;
        end
        if (raddr_i == '0) begin
            rdata_o = '0;
        end
    end

endmodule

// File: rtl/register_file_32x32.sv
// MIPS integer register file: 32 x 32-bit storage, one synchronous write port,
// two combinational read ports with optional same-cycle write forwarding.
import mips_pkg::*;

module register_file_32x32 #(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int ADDR_W   = mips_pkg::ADDR_W,
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
    logic                            wr_act;

    assign wr_act = RegWrite && !Reset && (WriteReg != '0);

    // Reset wins over a simultaneous write; entry 0 is pinned to zero.
    always_comb begin
        regs_d = regs_q;
        if (Reset) begin
            regs_d = '0;
        end else if (wr_act) begin
            regs_d[WriteReg] = WriteData;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge Clk) begin
        regs_q <= regs_d;
    end

    regfile_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS),
        .BYPASS  (BYPASS)
    ) u_rd1 (
        .regs_i  (regs_q),
        .raddr_i (ReadReg1),
        .wr_act_i(wr_act),
        .waddr_i (WriteReg),
        .wdata_i (WriteData),
        .rdata_o (ReadData1)
    );

    regfile_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS),
        .BYPASS  (BYPASS)
    ) u_rd2 (
        .regs_i  (regs_q),
        .raddr_i (ReadReg2),
        .wr_act_i(wr_act),
        .waddr_i (WriteReg),
        .wdata_i (WriteData),
        .rdata_o (ReadData2)
    );

endmodule

// File: tb/tb_register_file_32x32.sv
// Bench for register_file_32x32: a forwarding and a non-forwarding instance share
// stimulus; an array model is compared every cycle, plus directed literal checks.
module tb_register_file_32x32;

    logic        Clk;
    logic        Reset;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [31:0] rd1_byp, rd2_byp, rd1_nob, rd2_nob;

    int n_checks = 0;
    int n_errs   = 0;

    logic [31:0] mem [32];
    bit          model_ok = 1'b0;

    register_file_32x32 #(.BYPASS(1'b1)) u_byp (
        .Clk(Clk), .Reset(Reset), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .ReadData1(rd1_byp), .ReadData2(rd2_byp)
    );

    register_file_32x32 #(.BYPASS(1'b0)) u_nob (
        .Clk(Clk), .Reset(Reset), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .ReadData1(rd1_nob), .ReadData2(rd2_nob)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: plain array written at each rising edge.
    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            model_ok <= 1'b1;
        end else if (RegWrite && WriteReg != 5'd0) begin
            mem[WriteReg] <= WriteData;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] idx, input bit byp);
        if (idx == 5'd0) return 32'h0;
        if (byp && RegWrite && !Reset && WriteReg == idx) return WriteData;
        return mem[idx];
    endfunction

    always @(negedge Clk) begin
        if (model_ok) begin
            check("model_rd1_byp", rd1_byp, exp_rd(ReadReg1, 1'b1));
            check("model_rd2_byp", rd2_byp, exp_rd(ReadReg2, 1'b1));
            check("model_rd1_nob", rd1_nob, exp_rd(ReadReg1, 1'b0));
            check("model_rd2_nob", rd2_nob, exp_rd(ReadReg2, 1'b0));
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1; RegWrite = 1'b0; WriteReg = 5'd0; WriteData = 32'h0;
        ReadReg1 = 5'd0; ReadReg2 = 5'd0;
        step();
        Reset = 1'b0;

        // Everything reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i);
            ReadReg2 = 5'(31 - i);
            #1;
            check($sformatf("sweep_rd1_byp_%0d", i), rd1_byp, 32'h0);
            check($sformatf("sweep_rd2_nob_%0d", i), rd2_nob, 32'h0);
            step();
        end

        // Plain write to $5.
        RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF;
        step();
        RegWrite = 1'b0; ReadReg1 = 5'd5; ReadReg2 = 5'd5;
        #1;
        check("wr5_rd1_byp", rd1_byp, 32'hDEADBEEF);
        check("wr5_rd2_byp", rd2_byp, 32'hDEADBEEF);
        check("wr5_rd1_nob", rd1_nob, 32'hDEADBEEF);
        check("wr5_rd2_nob", rd2_nob, 32'hDEADBEEF);
        ReadReg2 = 5'd6;
        #1;
        check("wr5_other_zero", rd2_byp, 32'h0);
        step();

        // Writes to $0 are dropped and never forwarded.
        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFFFFFF; ReadReg1 = 5'd0;
        #1;
        check("r0_before_byp", rd1_byp, 32'h0);
        step();
        RegWrite = 1'b0;
        #1;
        check("r0_after_byp", rd1_byp, 32'h0);
        check("r0_after_nob", rd1_nob, 32'h0);

        // Forwarding versus stored value on a same-cycle write.
        RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'h00001234;
        step();
        WriteData = 32'h0000ABCD; ReadReg2 = 5'd9;
        #1;
        check("fwd_before_byp", rd2_byp, 32'h0000ABCD);
        check("fwd_before_nob", rd2_nob, 32'h00001234);
        step();
        RegWrite = 1'b0;
        #1;
        check("fwd_after_byp", rd2_byp, 32'h0000ABCD);
        check("fwd_after_nob", rd2_nob, 32'h0000ABCD);

        // Fill 1..31, then reset with a colliding write.
        for (int i = 1; i < 32; i++) begin
            RegWrite = 1'b1; WriteReg = 5'(i); WriteData = 32'(i * 1000 + 1000);
            step();
        end
        RegWrite = 1'b0; ReadReg1 = 5'd31; ReadReg2 = 5'd1;
        #1;
        check("fill_r31", rd1_byp, 32'd32000);
        check("fill_r1", rd2_nob, 32'd2000);
        Reset = 1'b1; RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h00000777; ReadReg1 = 5'd3;
        #1;
        check("rst_no_fwd_byp", rd1_byp, 32'd4000);
        step();
        Reset = 1'b0; RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i);
            ReadReg2 = 5'(i);
            #1;
            check($sformatf("postrst_rd1_byp_%0d", i), rd1_byp, 32'h0);
            check($sformatf("postrst_rd2_nob_%0d", i), rd2_nob, 32'h0);
            step();
        end

        // Random traffic, checked by the model every cycle.
        for (int n = 0; n < 16; n++) begin
            ReadReg1  = 5'($urandom_range(0, 31));
            ReadReg2  = 5'($urandom_range(0, 31));
            WriteReg  = 5'($urandom_range(0, 31));
            WriteData = $urandom;
            RegWrite  = 1'($urandom_range(0, 1));
            if (n % 4 == 0) ReadReg2 = WriteReg;
            step();
        end
        RegWrite = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
